// File: rtl/status_register_unit.sv
`default_nettype none
// ==========================================================================
// status_register_unit : NZCV status register with EX forwarding, exception
//                        save/restore and a saturating flag-update counter.
// Revision 1.0
// ==========================================================================
module status_register_unit #(
    parameter int LEN_STATUS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic                  ex_s_bit,
    input  logic                  ex_cond_pass,
    input  logic [LEN_STATUS-1:0] ex_alu_status,
    input  logic                  exc_entry,
    input  logic                  exc_return,
    output logic [LEN_STATUS-1:0] status_out,
    output logic [LEN_STATUS-1:0] status_q,
    output logic [LEN_STATUS-1:0] saved_status,
    output logic                  in_exception,
    output logic                  exc_error,
    output logic [CNT_W-1:0]      flag_update_count
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_EXC    = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_STATUS-1:0] status_d;
    logic [LEN_STATUS-1:0] saved_q, saved_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  w_fwd_en;
    logic                  w_wr_en;
    logic                  w_cnt_inc;

    // Forwarding ignores freeze: a stalled EX instruction still commits later.
    assign w_fwd_en = ex_valid & ex_s_bit & ex_cond_pass & ~flush;
    assign w_wr_en  = w_fwd_en & ~freeze;

    assign status_out = w_fwd_en ? ex_alu_status : status_q;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        saved_d   = saved_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        w_cnt_inc = 1'b0;

        if (!freeze) begin
            if (w_wr_en) begin
                status_d  = ex_alu_status;
                w_cnt_inc = 1'b1;
            end

            if (exc_entry && exc_return) begin
                err_d = 1'b1;
            end else if (exc_entry) begin
                if (state_q == ST_NORMAL) begin
                    state_d = ST_EXC;
                    saved_d = w_wr_en ? ex_alu_status : status_q;
                end else begin
                    err_d = 1'b1;
                end
            end else if (exc_return) begin
                if (state_q == ST_EXC) begin
                    // Restore wins over a same-cycle commit, which is dropped.
                    state_d   = ST_NORMAL;
                    status_d  = saved_q;
                    w_cnt_inc = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end

            if (w_cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_NORMAL;
            status_q <= '0;
            saved_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            saved_q  <= saved_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign saved_status      = saved_q;
    assign in_exception      = (state_q == ST_EXC);
    assign exc_error         = err_q;
    assign flag_update_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_status_register_unit.sv
`default_nettype none
// Testbench for status_register_unit: directed vector table, randomized run
// against a behavioural model, and an asynchronous mid-cycle reset.
module tb_status_register_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       freeze = 1'b0, flush = 1'b0, ex_valid = 1'b0, ex_s_bit = 1'b0, ex_cond_pass = 1'b0;
    logic [3:0] ex_alu_status = 4'h0;
    logic       exc_entry = 1'b0, exc_return = 1'b0;
    logic [3:0] status_out, status_q, saved_status;
    logic       in_exception, exc_error;
    logic [15:0] cnt16;
    logic [3:0] status_out2, status_q2, saved_status2;
    logic       in_exception2, exc_error2;
    logic [1:0] cnt2;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [3:0] m_q, m_saved;
    logic       m_exc, m_err;
    int         m_cnt;

    status_register_unit #(.LEN_STATUS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .ex_valid(ex_valid),
        .ex_s_bit(ex_s_bit), .ex_cond_pass(ex_cond_pass), .ex_alu_status(ex_alu_status),
        .exc_entry(exc_entry), .exc_return(exc_return), .status_out(status_out),
        .status_q(status_q), .saved_status(saved_status), .in_exception(in_exception),
        .exc_error(exc_error), .flag_update_count(cnt16)
    );

    status_register_unit #(.LEN_STATUS(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .ex_valid(ex_valid),
        .ex_s_bit(ex_s_bit), .ex_cond_pass(ex_cond_pass), .ex_alu_status(ex_alu_status),
        .exc_entry(exc_entry), .exc_return(exc_return), .status_out(status_out2),
        .status_q(status_q2), .saved_status(saved_status2), .in_exception(in_exception2),
        .exc_error(exc_error2), .flag_update_count(cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fz, fl, v, s, p;
        logic [3:0] alu;
        logic       en, rt;
        logic [3:0] e_out, e_q, e_sv;
        logic       e_ie, e_er;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic fz, fl, v, s, p, input logic [3:0] alu,
                                input logic en, rt, input logic [3:0] e_out, e_q, e_sv,
                                input logic e_ie, e_er, input int e_cnt);
        vec_t r;
        r.fz = fz; r.fl = fl; r.v = v; r.s = s; r.p = p; r.alu = alu;
        r.en = en; r.rt = rt; r.e_out = e_out; r.e_q = e_q; r.e_sv = e_sv;
        r.e_ie = e_ie; r.e_er = e_er; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic apply(input vec_t t);
        freeze = t.fz; flush = t.fl; ex_valid = t.v; ex_s_bit = t.s; ex_cond_pass = t.p;
        ex_alu_status = t.alu; exc_entry = t.en; exc_return = t.rt;
    endtask

    task automatic model_reset();
        m_q = 4'h0; m_saved = 4'h0; m_exc = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    // Architectural rules applied once per clock edge.
    task automatic model_step();
        logic fwd, wr;
        logic [3:0] nq;
        int ncnt;
        fwd = ex_valid && ex_s_bit && ex_cond_pass && !flush;
        wr  = fwd && !freeze;
        if (!freeze) begin
            nq   = wr ? ex_alu_status : m_q;
            ncnt = m_cnt + (wr ? 1 : 0);
            if (exc_entry && exc_return) m_err = 1'b1;
            else if (exc_entry) begin
                if (!m_exc) begin m_exc = 1'b1; m_saved = wr ? ex_alu_status : m_q; end
                else m_err = 1'b1;
            end else if (exc_return) begin
                if (m_exc) begin m_exc = 1'b0; nq = m_saved; ncnt = m_cnt; end
                else m_err = 1'b1;
            end
            m_q = nq; m_cnt = ncnt;
        end
    endtask

    function automatic logic [3:0] model_out();
        return (ex_valid && ex_s_bit && ex_cond_pass && !flush) ? ex_alu_status : m_q;
    endfunction

    task automatic check_outputs(input logic [3:0] e_out, e_q, e_sv, input logic e_ie, e_er,
                                 input int e_cnt);
        chk("status_out", status_out, e_out);
        chk("status_q", status_q, e_q);
        chk("saved_status", saved_status, e_sv);
        chk("in_exception", in_exception, e_ie);
        chk("exc_error", exc_error, e_er);
        chk("count16", cnt16, sat(e_cnt, 65535));
        chk("count2", cnt2, sat(e_cnt, 3));
    endtask

    initial begin
        vec_t r;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 0);
        rst = 1'b0;

        //          fz fl v  s  p  alu    en rt  out    q      sv     ie er cnt
        tbl.push_back(mk(0,0,1,1,1,4'b0100,0,0, 4'b0100,4'b0000,4'b0000,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,4'b1111,0,0, 4'b0100,4'b0100,4'b0000,0,0,1));
        tbl.push_back(mk(0,0,1,1,0,4'b1111,0,0, 4'b0100,4'b0100,4'b0000,0,0,1));
        tbl.push_back(mk(0,0,1,0,1,4'b1111,0,0, 4'b0100,4'b0100,4'b0000,0,0,1));
        tbl.push_back(mk(0,1,1,1,1,4'b1111,0,0, 4'b0100,4'b0100,4'b0000,0,0,1));
        tbl.push_back(mk(1,0,1,1,1,4'b1000,0,0, 4'b1000,4'b0100,4'b0000,0,0,1));
        tbl.push_back(mk(1,0,1,1,1,4'b1000,0,0, 4'b1000,4'b0100,4'b0000,0,0,1));
        tbl.push_back(mk(1,0,1,1,1,4'b1000,0,0, 4'b1000,4'b0100,4'b0000,0,0,1));
        tbl.push_back(mk(0,0,1,1,1,4'b1000,0,0, 4'b1000,4'b0100,4'b0000,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,4'b0000,0,0, 4'b1000,4'b1000,4'b0000,0,0,2));
        tbl.push_back(mk(0,0,1,1,1,4'b0010,0,0, 4'b0010,4'b1000,4'b0000,0,0,2));
        tbl.push_back(mk(0,0,1,1,1,4'b1001,1,0, 4'b1001,4'b0010,4'b0000,0,0,3));
        tbl.push_back(mk(0,0,1,1,1,4'b0100,0,0, 4'b0100,4'b1001,4'b1001,1,0,4));
        tbl.push_back(mk(0,0,1,1,1,4'b0111,0,1, 4'b0111,4'b0100,4'b1001,1,0,5));
        tbl.push_back(mk(0,0,0,0,0,4'b0000,0,0, 4'b1001,4'b1001,4'b1001,0,0,5));
        tbl.push_back(mk(0,0,0,0,0,4'b0000,0,1, 4'b1001,4'b1001,4'b1001,0,0,5));
        tbl.push_back(mk(0,0,1,1,1,4'b0011,1,0, 4'b0011,4'b1001,4'b1001,0,1,5));
        tbl.push_back(mk(0,0,1,1,1,4'b1100,1,0, 4'b1100,4'b0011,4'b0011,1,1,6));
        tbl.push_back(mk(0,0,0,0,0,4'b0000,1,1, 4'b1100,4'b1100,4'b0011,1,1,7));
        tbl.push_back(mk(1,0,0,0,0,4'b0000,0,1, 4'b1100,4'b1100,4'b0011,1,1,7));
        tbl.push_back(mk(0,0,0,0,0,4'b0000,0,0, 4'b1100,4'b1100,4'b0011,1,1,7));

        foreach (tbl[i]) begin
            r = tbl[i];
            apply(r);
            #2;
            check_outputs(r.e_out, r.e_q, r.e_sv, r.e_ie, r.e_er, r.e_cnt);
            @(posedge clk);
            model_step();
            #1;
        end

        // Randomized run from the state the table left behind.
        for (int k = 0; k < 300; k++) begin
            r.fz = ($urandom_range(3) == 0); r.fl = ($urandom_range(7) == 0);
            r.v = ($urandom_range(7) != 0); r.s = ($urandom_range(3) != 0);
            r.p = ($urandom_range(3) != 0); r.alu = 4'($urandom_range(15));
            r.en = ($urandom_range(9) == 0); r.rt = ($urandom_range(9) == 0);
            apply(r);
            #2;
            check_outputs(model_out(), m_q, m_saved, m_exc, m_err, m_cnt);
            @(posedge clk);
            model_step();
            #1;
        end

        // Asynchronous reset mid-cycle while a commit is pending.
        r = mk(0,0,1,1,1,4'b0110,0,0, 4'b0110,4'b0,4'b0,0,0,0);
        apply(r);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_status_q", status_q, 0);
        chk("rst_saved", saved_status, 0);
        chk("rst_in_exc", in_exception, 0);
        chk("rst_err", exc_error, 0);
        chk("rst_count16", cnt16, 0);
        chk("rst_count2", cnt2, 0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        #1;
        chk("rst_status_out", status_out, 0);
        chk("rst_hold_q", status_q, 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
